// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared combinational ALU.
// Ports: clk/rst, req0_*/req1_* valid-ready operation inputs,
// alu_* drive/result of the shared ALU, rsp_* captured response
// (valid-ready), busy = not idle.
module alu_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [3:0]        req0_ctl,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [3:0]        req1_ctl,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic [3:0]        alu_ctl,
  output logic [DATA_W-1:0] alu_data_1,
  output logic [DATA_W-1:0] alu_data_2,
  input  logic [DATA_W-1:0] alu_res,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_res,
  output logic              rsp_zero,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  logic              last_grant;
  logic [3:0]        op_ctl;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              op_id;
  logic              gnt0;
  logic              gnt1;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    gnt0 = req0_valid && (!req1_valid || last_grant);
    gnt1 = req1_valid && (!req0_valid || !last_grant);
  end

  // Readys and busy are masked by rst so nothing is offered
  // while a reset is pending.
  assign req0_ready = !rst && (state == IDLE) && gnt0;
  assign req1_ready = !rst && (state == IDLE) && gnt1;
  assign busy       = !rst && (state != IDLE);

  assign alu_ctl    = op_ctl;
  assign alu_data_1 = op_a;
  assign alu_data_2 = op_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      op_ctl     <= '0;
      op_a       <= '0;
      op_b       <= '0;
      op_id      <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_res    <= '0;
      rsp_zero   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req0_ready) begin
            op_ctl     <= req0_ctl;
            op_a       <= req0_a;
            op_b       <= req0_b;
            op_id      <= 1'b0;
            last_grant <= 1'b0;
            state      <= EXEC;
          end else if (req1_ready) begin
            op_ctl     <= req1_ctl;
            op_a       <= req1_a;
            op_b       <= req1_b;
            op_id      <= 1'b1;
            last_grant <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_res   <= alu_res;
          rsp_zero  <= alu_zero;
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of the arbiter.
module tb_alu_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid = 0, req1_valid = 0;
  logic         req0_ready, req1_ready;
  logic [3:0]   req0_ctl = 0, req1_ctl = 0;
  logic [W-1:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [3:0]   alu_ctl;
  logic [W-1:0] alu_data_1, alu_data_2, alu_res;
  logic         alu_zero;
  logic         rsp_valid, rsp_ready = 0, rsp_id, rsp_zero, busy;
  logic [W-1:0] rsp_res;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_ctl(req0_ctl), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_ctl(req1_ctl), .req1_a(req1_a), .req1_b(req1_b),
    .alu_ctl(alu_ctl), .alu_data_1(alu_data_1),
    .alu_data_2(alu_data_2), .alu_res(alu_res),
    .alu_zero(alu_zero), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_res(rsp_res), .rsp_zero(rsp_zero), .busy(busy)
  );

  // ALU encoding: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT, C NOR.
  function automatic logic [W-1:0] alu_fn(
    input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    case (c)
      4'h0: return a & b;
      4'h1: return a | b;
      4'h2: return a + b;
      4'h6: return a - b;
      4'h7: return ($signed(a) < $signed(b)) ? 1 : 0;
      4'hC: return ~(a | b);
      default: return '0;
    endcase
  endfunction

  always_comb begin
    alu_res  = alu_fn(alu_ctl, alu_data_1, alu_data_2);
    alu_zero = (alu_res == '0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; req0_valid = 1; req1_valid = 1;
    #1;
    total++;
    if ({req0_ready, req1_ready, busy} !== 3'b000) begin
      bad++;
      $display("FAIL rst_ready got=%b exp=000",
               {req0_ready, req1_ready, busy});
    end
    tick(); tick();
    total++;
    if ({alu_ctl, alu_data_1, alu_data_2, rsp_valid, rsp_res,
         rsp_zero, rsp_id, req0_ready, req1_ready, busy} !== '0) begin
      bad++;
      $display("FAIL rst_outs got ctl=%h d1=%h d2=%h v=%b r=%h z=%b id=%b",
               alu_ctl, alu_data_1, alu_data_2, rsp_valid, rsp_res,
               rsp_zero, rsp_id);
    end
    rst = 0; req0_valid = 0; req1_valid = 0;
    tick();
  endtask

  task automatic test_single();
    req0_valid = 1; req0_ctl = 4'h2; req0_a = 5; req0_b = 7;
    rsp_ready = 1;
    #1;
    total++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      bad++;
      $display("FAIL single_ready got=%b exp=10",
               {req0_ready, req1_ready});
    end
    tick();
    req0_valid = 0;
    #1;
    total++;
    if ({busy, rsp_valid, alu_ctl, alu_data_1, alu_data_2} !==
        {1'b1, 1'b0, 4'h2, 32'd5, 32'd7}) begin
      bad++;
      $display("FAIL single_exec got b=%b v=%b ctl=%h d1=%0d d2=%0d exp 1 0 2 5 7",
               busy, rsp_valid, alu_ctl, alu_data_1, alu_data_2);
    end
    tick();
    total++;
    if ({rsp_valid, rsp_res, rsp_zero, rsp_id} !== {1'b1, 32'd12, 2'b00}) begin
      bad++;
      $display("FAIL single_rsp got v=%b r=%0d z=%b id=%b exp 1 12 0 0",
               rsp_valid, rsp_res, rsp_zero, rsp_id);
    end
    tick();
    total++;
    if ({busy, rsp_valid, rsp_res} !== {2'b00, 32'd12}) begin
      bad++;
      $display("FAIL single_idle got b=%b v=%b r=%0d exp 0 0 12",
               busy, rsp_valid, rsp_res);
    end
  endtask

  task automatic test_zero();
    req1_valid = 1; req1_ctl = 4'h6; req1_a = 9; req1_b = 9;
    rsp_ready = 1;
    #1;
    total++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      bad++;
      $display("FAIL zero_ready got=%b exp=01", {req0_ready, req1_ready});
    end
    tick();
    req1_valid = 0;
    tick();
    total++;
    if ({rsp_valid, rsp_res, rsp_zero, rsp_id} !== {1'b1, 32'd0, 2'b11}) begin
      bad++;
      $display("FAIL zero_rsp got v=%b r=%0d z=%b id=%b exp 1 0 1 1",
               rsp_valid, rsp_res, rsp_zero, rsp_id);
    end
    tick();
  endtask

  task automatic test_tie();
    rst = 1; tick(); rst = 0;
    req0_valid = 1; req0_ctl = 4'h1; req0_a = 'hF0; req0_b = 'h0F;
    req1_valid = 1; req1_ctl = 4'h0; req1_a = 'hFF; req1_b = 'h0F;
    rsp_ready = 1;
    for (int k = 0; k < 6; k++) begin
      int n = 0;
      logic want;
      logic [W-1:0] wres;
      want = k[0];
      wres = want ? 'h0F : 'hFF;
      #1;
      while (!(req0_ready || req1_ready) && n < 5) begin
        tick();
        n++;
      end
      total++;
      if (n == 5 || {req0_ready, req1_ready} !== {~want, want}) begin
        bad++;
        $display("FAIL tie_grant op=%0d got=%b exp=%b",
                 k, {req0_ready, req1_ready}, {~want, want});
      end
      tick(); tick();
      total++;
      if ({rsp_valid, rsp_id, rsp_res} !== {1'b1, want, wres}) begin
        bad++;
        $display("FAIL tie_rsp op=%0d got v=%b id=%b r=%h exp 1 %b %h",
                 k, rsp_valid, rsp_id, rsp_res, want, wres);
      end
      tick();
    end
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic test_backpressure();
    req0_valid = 1; req0_ctl = 4'h2; req0_a = 100; req0_b = 23;
    rsp_ready = 0;
    tick();
    req1_valid = 1;
    tick();
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({rsp_valid, rsp_res, req0_ready, req1_ready, busy} !==
          {1'b1, 32'd123, 3'b001}) begin
        bad++;
        $display("FAIL bp_hold cyc=%0d got v=%b r=%0d rd=%b%b b=%b",
                 i, rsp_valid, rsp_res, req0_ready, req1_ready, busy);
      end
      tick();
    end
    rsp_ready = 1; req0_valid = 0; req1_valid = 0;
    #1;
    total++;
    if (rsp_valid !== 1'b1) begin
      bad++;
      $display("FAIL bp_release got=%b exp=1", rsp_valid);
    end
    tick();
    total++;
    if ({busy, rsp_valid, rsp_res} !== {2'b00, 32'd123}) begin
      bad++;
      $display("FAIL bp_idle got b=%b v=%b r=%0d exp 0 0 123",
               busy, rsp_valid, rsp_res);
    end
  endtask

  task automatic test_reset_mid();
    req0_valid = 1; req0_ctl = 4'hC; req0_a = 0; req0_b = 0;
    rsp_ready = 1;
    tick();
    rst = 1; req1_valid = 1;
    #1;
    total++;
    if ({req0_ready, req1_ready, busy} !== 3'b000) begin
      bad++;
      $display("FAIL mid_rst got=%b exp=000",
               {req0_ready, req1_ready, busy});
    end
    tick();
    rst = 0; req0_valid = 0; req1_valid = 0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({rsp_valid, alu_ctl, alu_data_1, alu_data_2, rsp_res,
           rsp_id, rsp_zero, busy} !== '0) begin
        bad++;
        $display("FAIL mid_outs cyc=%0d v=%b ctl=%h r=%h id=%b b=%b",
                 i, rsp_valid, alu_ctl, rsp_res, rsp_id, busy);
      end
      tick();
    end
    req0_valid = 1; req1_valid = 1;
    #1;
    total++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      bad++;
      $display("FAIL mid_tie got=%b exp=10", {req0_ready, req1_ready});
    end
    req0_valid = 0; req1_valid = 0;
    tick();
  endtask

  task automatic test_random();
    bit           inflight = 0;
    int           age = 0;
    bit           m_last = 1;
    bit           e_id = 0;
    logic [W-1:0] e_res = '0;
    for (int c = 0; c < 400; c++) begin
      bit r0, r1, ev;
      req0_valid = ($urandom_range(0, 9) < 6);
      req1_valid = ($urandom_range(0, 9) < 6);
      req0_ctl = 4'($urandom_range(0, 15));
      req1_ctl = 4'($urandom_range(0, 15));
      req0_a = $urandom; req0_b = $urandom_range(0, 1) ? req0_a : $urandom;
      req1_a = $urandom; req1_b = $urandom_range(0, 1) ? req1_a : $urandom;
      rsp_ready = $urandom_range(0, 1);
      #1;
      r0 = !inflight && req0_valid && (!req1_valid || m_last);
      r1 = !inflight && req1_valid && (!req0_valid || !m_last);
      ev = inflight && age >= 2;
      total++;
      if ({req0_ready, req1_ready, busy, rsp_valid} !==
          {r0, r1, inflight, ev}) begin
        bad++;
        $display("FAIL rnd_ctl cyc=%0d got=%b exp=%b", c,
                 {req0_ready, req1_ready, busy, rsp_valid},
                 {r0, r1, inflight, ev});
      end
      if (ev) begin
        total++;
        if ({rsp_id, rsp_res, rsp_zero} !== {e_id, e_res, e_res == '0}) begin
          bad++;
          $display("FAIL rnd_rsp cyc=%0d got id=%b r=%h z=%b exp %b %h %b",
                   c, rsp_id, rsp_res, rsp_zero, e_id, e_res, e_res == '0);
        end
      end
      if (inflight) begin
        if (ev && rsp_ready) inflight = 0;
        else age++;
      end else if (r0 || r1) begin
        inflight = 1;
        age = 1;
        e_id = r1;
        m_last = r1;
        e_res = r1 ? alu_fn(req1_ctl, req1_a, req1_b)
                   : alu_fn(req0_ctl, req0_a, req0_b);
      end
      tick();
    end
    req0_valid = 0; req1_valid = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_zero();
    test_tie();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter: DATA_W, 32, operand/result width (must match ALU datapath).
REQ-002 SHALL have ports (clock and reset first):
- clk  in  1  single system clock; all state on rising edge
- rst  in  1  synchronous active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_ctl  in  4  ALU control code (alu_ops.vh encoding)
- req0_a, req0_b  in  DATA_W  operands
- req1_valid, req1_ready, req1_ctl, req1_a, req1_b  same as requester 0
- alu_ctl  out  4  to shared ALU ctl
- alu_data_1, alu_data_2  out  DATA_W  to shared ALU operands
- alu_res  in  DATA_W  from shared ALU result
- alu_zero  in  1  from shared ALU zero flag
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester index owning response
- rsp_res  out  DATA_W  captured result
- rsp_zero  out  1  captured zero flag
- busy  out  1  high whenever state is not IDLE
REQ-003 SHALL treat the shared ALU as purely combinational: alu_res/alu_zero valid in the same cycle alu_* inputs are driven.

Function
REQ-004 SHALL implement FSM states IDLE, EXEC, RESP; transitions only on rising clk.
REQ-005 IDLE: grant computed combinationally from valids; reqN_ready = (state==IDLE) && grant==N && reqN_valid; at most one ready high per cycle.
REQ-006 Arbitration: only one valid -> grant it; both valid -> grant requester not in last_grant register; neither -> no ready, stay IDLE.
REQ-007 last_grant SHALL update to the granted index on each accepted handshake only.
REQ-008 On handshake (valid && ready) SHALL latch ctl, a, b and index into operand registers and move to EXEC.
REQ-009 alu_ctl, alu_data_1, alu_data_2 SHALL be driven directly from the operand registers in all states (stable, glitch-free between handshakes).
REQ-010 EXEC (exactly one cycle): SHALL capture alu_res into rsp_res, alu_zero into rsp_zero, latched index into rsp_id, set rsp_valid, move to RESP.
REQ-011 RESP: rsp_valid held high with rsp_res/rsp_zero/rsp_id stable until rsp_ready; on rsp_valid && rsp_ready clear rsp_valid and move to IDLE; rsp_res/rsp_zero/rsp_id retain value after.
REQ-012 Latency: handshake cycle T -> rsp_valid high at T+2; with rsp_ready held high, next acceptance possible at T+3 (throughput 1 op per 3 cycles).
REQ-013 No request SHALL be accepted in EXEC or RESP; requesters must hold valid and operands until ready (arbiter does not sample unaccepted requests).
REQ-014 rsp_ready asserted while rsp_valid low SHALL have no effect.
REQ-015 A requester dropping valid before ready SHALL lose its turn with no state change.
REQ-016 busy = (state != IDLE).
REQ-017 Unknown ctl codes SHALL be passed through unchanged; result is whatever the ALU returns (0 for unsupported codes).
REQ-018 Fairness: with both requesters continuously valid, grants SHALL strictly alternate 0,1,0,1...

Reset
REQ-019 rst high at a clk edge SHALL force: state IDLE, last_grant=1 (requester 0 wins first tie), operand regs 0 (alu_ctl=0, alu_data_1=0, alu_data_2=0), rsp_valid=0, rsp_res=0, rsp_zero=0, rsp_id=0.
REQ-020 While rst high, req0_ready and req1_ready SHALL be 0 and busy 0.
REQ-021 rst asserted in EXEC or RESP SHALL abort the operation; the in-flight response is discarded and never presented.

Verification
REQ-022 Single op: req0 ADD a=5 b=7, rsp_ready=1 -> req0_ready at T, rsp_valid at T+2 with rsp_res=12, rsp_zero=0, rsp_id=0, IDLE at T+3.
REQ-023 Zero flag: req1 SUB a=9 b=9 -> rsp_res=0, rsp_zero=1, rsp_id=1.
REQ-024 Tie after reset: both valid (req0 OR 0xF0/0x0F, req1 AND 0xFF/0x0F) held -> first grant req0 (rsp_res=0xFF), second req1 (rsp_res=0x0F), then alternates for 6 ops.
REQ-025 Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid and rsp_res stable, both readys 0, busy 1; release -> one-cycle handshake, IDLE next cycle.
REQ-026 Reset mid-op: rst pulsed in EXEC of NOR 0/0 -> rsp_valid never rises, all outputs 0, next tie grants req0.
